// File: rtl/wave_voice.sv
// Oscillator voice: phase accumulator driving a saw/triangle/pulse/noise waveshaper.
// Mode and duty are latched only at a period start so waveform edits never glitch mid-cycle.
module wave_voice #(
    parameter int unsigned SAMPLE_W = 8,
    parameter int unsigned PHASE_W  = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                sync_i,
    input  logic [PHASE_W-1:0]  freq_word_i,
    input  logic [1:0]          mode_i,
    input  logic [SAMPLE_W-1:0] duty_i,
    output logic [SAMPLE_W-1:0] sample_o,
    output logic                sample_valid_o,
    output logic                wrap_o
);

    localparam logic [1:0] ModeSaw   = 2'b00;
    localparam logic [1:0] ModeTri   = 2'b01;
    localparam logic [1:0] ModePulse = 2'b10;

    localparam logic [SAMPLE_W-1:0] SampleMax = {SAMPLE_W{1'b1}};
    localparam logic [SAMPLE_W-1:0] DutyInit  = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic [15:0]         LfsrSeed  = 16'hACE1;

    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [1:0]          mode_q, mode_d;
    logic [SAMPLE_W-1:0] duty_q, duty_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                valid_q, wrap_q;

    logic [PHASE_W:0]    sum;
    logic                carry;
    logic [SAMPLE_W-1:0] q;
    logic [SAMPLE_W-1:0] tri_t;

    always_comb begin
        sum     = {1'b0, phase_q} + {1'b0, freq_word_i};
        phase_d = sum[PHASE_W-1:0];
        carry   = sum[PHASE_W];
        if (sync_i) begin
            phase_d = '0;
            carry   = 1'b1;
        end

        mode_d = carry ? mode_i : mode_q;
        duty_d = carry ? duty_i : duty_q;
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

        // Shaping uses the post-update phase/mode/duty/lfsr so the sample is one clock behind en.
        q     = phase_d[PHASE_W-1 -: SAMPLE_W];
        tri_t = {q[SAMPLE_W-2:0], 1'b0};
        case (mode_d)
            ModeSaw:   sample_d = q;
            ModeTri:   sample_d = q[SAMPLE_W-1] ? ~tri_t : tri_t;
            ModePulse: sample_d = (q < duty_d) ? SampleMax : '0;
            default:   sample_d = lfsr_d[SAMPLE_W-1:0];
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q  <= '0;
            mode_q   <= ModeSaw;
            duty_q   <= DutyInit;
            lfsr_q   <= LfsrSeed;
            sample_q <= '0;
            valid_q  <= 1'b0;
            wrap_q   <= 1'b0;
        end else if (en_i) begin
            phase_q  <= phase_d;
            mode_q   <= mode_d;
            duty_q   <= duty_d;
            lfsr_q   <= lfsr_d;
            sample_q <= sample_d;
            valid_q  <= 1'b1;
            wrap_q   <= carry;
        end else begin
            valid_q  <= 1'b0;
            wrap_q   <= 1'b0;
        end
    end

    assign sample_o       = sample_q;
    assign sample_valid_o = valid_q;
    assign wrap_o         = wrap_q;

endmodule

// File: doc/wave_voice.md
Name: wave_voice

Overview:
- Parametrised, clocked oscillator voice: phase accumulator feeding a multi-mode waveshaper.
- Modes: saw, triangle, variable-duty pulse, LFSR noise.
- Mode/duty changes are glitch-free: they take effect only at a phase wrap or a hard sync.
- Sits between the note/frequency control logic and the mixer/PWM output stage; one instance per synth voice.

Parameters:
- SAMPLE_W, 8, sample/duty width; 2 ≤ SAMPLE_W ≤ 16.
- PHASE_W, 16, phase accumulator width; PHASE_W ≥ SAMPLE_W.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  sample-rate tick; one accumulation step per cycle high
- sync  in  1  hard sync; only acted on when en=1
- freq_word  in  PHASE_W  phase increment per en
- mode  in  2  requested mode: 00 saw, 01 triangle, 10 pulse, 11 noise
- duty  in  SAMPLE_W  requested pulse threshold
- sample  out  SAMPLE_W  registered waveform sample
- sample_valid  out  1  one-cycle pulse, new sample present
- wrap  out  1  one-cycle pulse, period start (carry or sync)

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at clk edge; overrides en/sync):
  - phase=0, sample=0, sample_valid=0, wrap=0.
  - active_mode=00, active_duty=2^(SAMPLE_W-1), lfsr=16'hACE1.
- en=0: all state holds; sample holds; sample_valid=0, wrap=0.
- en=1, sync=0:
  - phase_n = (phase + freq_word) mod 2^PHASE_W.
  - carry = carry-out of that add.
- en=1, sync=1: phase_n = 0, carry forced to 1.
- On every en=1 edge:
  - phase <= phase_n.
  - If carry: active_mode <= mode, active_duty <= duty.
  - lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]} (advances on every en, any mode).
  - sample <= shape(q, mode_n, duty_n, lfsr_n), registered on the same edge.
    - q = phase_n[PHASE_W-1 -: SAMPLE_W].
    - mode_n/duty_n/lfsr_n are the post-update values.
  - sample_valid <= 1; wrap <= carry.
- Latency: one clock from en edge to sample. Changes to mode/duty inputs between wraps have no effect until the next wrap or sync.
- Shape, all arithmetic mod 2^SAMPLE_W, MAX = 2^SAMPLE_W-1:
  - saw: q.
  - triangle: t=(q<<1) truncated; output t if q[MSB]=0, else ~t. Continuous; peak MAX at q=2^(SAMPLE_W-1).
  - pulse: MAX if q < duty, else 0. duty=0 gives constant 0; duty=MAX gives high except q=MAX.
  - noise: lfsr_n[SAMPLE_W-1:0].
- freq_word=0: phase frozen, no wraps; sample recomputed each en (noise still changes). Mode changes then require sync.
- Phase wraps silently modulo 2^PHASE_W; no overflow flag beyond wrap.
- Simultaneous sync and natural carry: single wrap pulse, phase=0.
- No combinational path from any input to any output.

Test Plan (SAMPLE_W=8, PHASE_W=16):
- Reset: rst=1 with en=1, sync=1 for 2 cycles → sample=0x00, sample_valid=0, wrap=0; en held low afterwards → sample_valid stays 0.
- Saw: mode=00, freq_word=0x0100, en every cycle → samples 0x01,0x02,…,0xFF,0x00. wrap=1 only with the 256th sample (0x00). sample_valid=1 every cycle.
- Triangle: mode=01, latch via sync, freq_word=0x0100:
  - Sequence 0x00 (sync), 0x02, 0x04, …; q=0x7F→0xFE, q=0x80→0xFF, q=0x81→0xFD, q=0xFF→0x01, then 0x00 with wrap=1.
- Pulse/glitch-free update: mode=10, duty=0x40 latched by sync, freq_word=0x0100 → 0xFF for q<0x40, else 0x00.
  - duty changed to 0xC0 at q=0x80 → threshold stays 0x40 until the wrap.
  - Next period: 0xFF for q<0xC0.
- Noise: after reset, mode=11, sync=1, en=1 → sample=0xC3 (lfsr 0x59C3), wrap=1. Subsequent en → samples follow the LFSR recurrence.
- Gating/sync/reset mid-run:
  - en toggled 1,0,0,1 → sample changes only on en edges; sample_valid=1 only on those edges.
  - sync with phase=0x8000 → next sample from q=0x00, wrap=1.
  - rst asserted mid-period → all outputs to reset values next edge; active_mode returns to saw.
